// File: rtl/interrupt_arbiter_if.sv
// Bus between the interrupt arbiter and the pins/controller side: raw lines, mask
// write port, acknowledge, and the request/status outputs.
interface interrupt_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
);
    logic [NUM_SRC-1:0] IrqIn;
    logic               MaskWE;
    logic [NUM_SRC-1:0] MaskWD;
    logic               IntAck;
    logic               Interrupt;
    logic [ID_W-1:0]    IrqId;
    logic [NUM_SRC-1:0] Pending;
    logic [NUM_SRC-1:0] Mask;

    modport master (
        output IrqIn, MaskWE, MaskWD, IntAck,
        input  Interrupt, IrqId, Pending, Mask
    );

    modport slave (
        input  IrqIn, MaskWE, MaskWD, IntAck,
        output Interrupt, IrqId, Pending, Mask
    );
endinterface

// File: rtl/interrupt_arbiter.sv
// Edge-latching, maskable, round-robin interrupt arbiter feeding a single
// Interrupt request line, with an ack-triggered holdoff before the next request.
module interrupt_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int ID_W        = 2,
    parameter int HOLDOFF_CYC = 2
) (
    input  logic               clk,
    input  logic               reset,
    interrupt_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_HOLDOFF} state_t;

    state_t             state_reg;
    logic [NUM_SRC-1:0] sync_reg;
    logic [NUM_SRC-1:0] sync_d_reg;
    logic [NUM_SRC-1:0] pending_reg;
    logic [NUM_SRC-1:0] mask_reg;
    logic [ID_W-1:0]    irq_id_reg;
    logic [ID_W-1:0]    last_served_reg;
    logic               irq_reg;
    logic [3:0]         count_reg;

    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    winner;
    logic               ack_fire;

    assign edge_det = sync_reg & ~sync_d_reg;
    assign eligible = pending_reg & mask_reg;
    assign ack_fire = (state_reg == ST_ASSERT) && bus.IntAck;

    // A fresh edge on the source being acknowledged must survive the clear.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_pend
            assign ack_clr[gi]      = ack_fire && (irq_id_reg == ID_W'(gi));
            assign pending_next[gi] = edge_det[gi] | (pending_reg[gi] & ~ack_clr[gi]);
        end
    endgenerate

    // Scan downward so the closest candidate after last_served is written last.
    always_comb begin
        logic [ID_W-1:0] idx;
        winner = '0;
        idx    = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = ID_W'((int'(last_served_reg) + k) % NUM_SRC);
            if (eligible[idx]) begin
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            sync_reg        <= '0;
            sync_d_reg      <= '0;
            pending_reg     <= '0;
            mask_reg        <= '0;
            irq_id_reg      <= '0;
            last_served_reg <= ID_W'(NUM_SRC - 1);
            irq_reg         <= 1'b0;
            count_reg       <= '0;
        end else begin
            sync_reg    <= bus.IrqIn;
            sync_d_reg  <= sync_reg;
            pending_reg <= pending_next;
            if (bus.MaskWE) begin
                mask_reg <= bus.MaskWD;
            end

            case (state_reg)
                ST_IDLE: begin
                    irq_reg <= 1'b0;
                    if (|eligible) begin
                        irq_id_reg <= winner;
                        irq_reg    <= 1'b1;
                        state_reg  <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (bus.IntAck) begin
                        last_served_reg <= irq_id_reg;
                        irq_reg         <= 1'b0;
                        count_reg       <= 4'(HOLDOFF_CYC);
                        state_reg       <= (HOLDOFF_CYC == 0) ? ST_IDLE : ST_HOLDOFF;
                    end else if (!mask_reg[irq_id_reg]) begin
                        irq_reg   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_HOLDOFF: begin
                    irq_reg <= 1'b0;
                    if (count_reg != 4'd0) begin
                        count_reg <= count_reg - 4'd1;
                    end
                    if (count_reg <= 4'd1) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    irq_reg   <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Interrupt = irq_reg;
    assign bus.IrqId     = irq_id_reg;
    assign bus.Pending   = pending_reg;
    assign bus.Mask      = mask_reg;
endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: latency, round-robin, masking, withdrawal,
// ack/edge collision and reset abort, each scenario checked inline.
module tb_interrupt_arbiter;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    interrupt_arbiter_if #(.NUM_SRC(4), .ID_W(2)) bus ();

    interrupt_arbiter #(.NUM_SRC(4), .ID_W(2), .HOLDOFF_CYC(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        bus.IrqIn  = '0;
        bus.MaskWE = 1'b0;
        bus.MaskWD = '0;
        bus.IntAck = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic set_mask(input logic [3:0] m);
        bus.MaskWE = 1'b1;
        bus.MaskWD = m;
        tick();
        bus.MaskWE = 1'b0;
    endtask

    task automatic test_reset();
        bus.IrqIn = 4'b1111;
        bus.MaskWE = 1'b1;
        bus.MaskWD = 4'b1111;
        reset = 1'b1;
        tick(); tick(); tick();
        do_reset();
        tests++; if (bus.Interrupt !== 1'b0) begin fails++; $display("FAIL reset_interrupt: got %b expected 0", bus.Interrupt); end
        tests++; if (bus.IrqId !== 2'd0) begin fails++; $display("FAIL reset_irqid: got %0d expected 0", bus.IrqId); end
        tests++; if (bus.Pending !== 4'b0000) begin fails++; $display("FAIL reset_pending: got %b expected 0000", bus.Pending); end
        tests++; if (bus.Mask !== 4'b0000) begin fails++; $display("FAIL reset_mask: got %b expected 0000", bus.Mask); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_latency();
        do_reset();
        set_mask(4'b1111);
        tests++; if (bus.Mask !== 4'b1111) begin fails++; $display("FAIL lat_mask: got %b expected 1111", bus.Mask); end
        bus.IrqIn = 4'b0100;
        tick(); tick();
        tests++; if (bus.Pending !== 4'b0100) begin fails++; $display("FAIL lat_pending: got %b expected 0100", bus.Pending); end
        tests++; if (bus.Interrupt !== 1'b0) begin fails++; $display("FAIL lat_early_int: got %b expected 0", bus.Interrupt); end
        tick();
        tests++; if (bus.Interrupt !== 1'b1) begin fails++; $display("FAIL lat_int: got %b expected 1", bus.Interrupt); end
        tests++; if (bus.IrqId !== 2'd2) begin fails++; $display("FAIL lat_id: got %0d expected 2", bus.IrqId); end
        bus.IntAck = 1'b1;
        tick();
        bus.IntAck = 1'b0;
        tests++; if (bus.Pending !== 4'b0000) begin fails++; $display("FAIL lat_ack_pending: got %b expected 0000", bus.Pending); end
        tests++; if (bus.Interrupt !== 1'b0) begin fails++; $display("FAIL lat_hold1: got %b expected 0", bus.Interrupt); end
        tick();
        tests++; if (bus.Interrupt !== 1'b0) begin fails++; $display("FAIL lat_hold2: got %b expected 0", bus.Interrupt); end
        bus.IrqIn = '0;
        $display("[TB] test_latency done");
    endtask

    task automatic test_round_robin();
        do_reset();
        set_mask(4'b1111);
        bus.IrqIn = 4'b1001;
        tick(); tick(); tick();
        tests++; if (bus.Interrupt !== 1'b1 || bus.IrqId !== 2'd0) begin fails++; $display("FAIL rr_first: got int=%b id=%0d expected int=1 id=0", bus.Interrupt, bus.IrqId); end
        bus.IntAck = 1'b1;
        tick();
        bus.IntAck = 1'b0;
        tests++; if (bus.Pending !== 4'b1000) begin fails++; $display("FAIL rr_pending: got %b expected 1000", bus.Pending); end
        tick(); tick();
        tests++; if (bus.Interrupt !== 1'b0) begin fails++; $display("FAIL rr_holdoff_end: got %b expected 0", bus.Interrupt); end
        tick();
        tests++; if (bus.Interrupt !== 1'b1 || bus.IrqId !== 2'd3) begin fails++; $display("FAIL rr_second: got int=%b id=%0d expected int=1 id=3", bus.Interrupt, bus.IrqId); end
        bus.IntAck = 1'b1;
        tick();
        bus.IntAck = 1'b0;
        bus.IrqIn = 4'b0000;
        tick(); tick();
        bus.IrqIn = 4'b1001;
        tick(); tick(); tick();
        tests++; if (bus.Interrupt !== 1'b1 || bus.IrqId !== 2'd0) begin fails++; $display("FAIL rr_wrap: got int=%b id=%0d expected int=1 id=0", bus.Interrupt, bus.IrqId); end
        bus.IrqIn = '0;
        $display("[TB] test_round_robin done");
    endtask

    task automatic test_masked_pending();
        do_reset();
        bus.IrqIn = 4'b0010;
        tick(); tick();
        tests++; if (bus.Pending !== 4'b0010) begin fails++; $display("FAIL mp_pending: got %b expected 0010", bus.Pending); end
        tick(); tick();
        tests++; if (bus.Interrupt !== 1'b0) begin fails++; $display("FAIL mp_masked_int: got %b expected 0", bus.Interrupt); end
        set_mask(4'b0010);
        tests++; if (bus.Interrupt !== 1'b0) begin fails++; $display("FAIL mp_mask_write_int: got %b expected 0", bus.Interrupt); end
        tick();
        tests++; if (bus.Interrupt !== 1'b1 || bus.IrqId !== 2'd1) begin fails++; $display("FAIL mp_unmask: got int=%b id=%0d expected int=1 id=1", bus.Interrupt, bus.IrqId); end
        bus.IrqIn = '0;
        $display("[TB] test_masked_pending done");
    endtask

    task automatic test_withdraw();
        do_reset();
        set_mask(4'b0010);
        bus.IrqIn = 4'b0010;
        tick(); tick(); tick();
        tests++; if (bus.Interrupt !== 1'b1 || bus.IrqId !== 2'd1) begin fails++; $display("FAIL wd_assert: got int=%b id=%0d expected int=1 id=1", bus.Interrupt, bus.IrqId); end
        set_mask(4'b0000);
        tick();
        tests++; if (bus.Interrupt !== 1'b0) begin fails++; $display("FAIL wd_int: got %b expected 0", bus.Interrupt); end
        tests++; if (bus.Pending !== 4'b0010) begin fails++; $display("FAIL wd_pending: got %b expected 0010", bus.Pending); end
        set_mask(4'b0010);
        tick();
        tests++; if (bus.Interrupt !== 1'b1 || bus.IrqId !== 2'd1) begin fails++; $display("FAIL wd_reassert: got int=%b id=%0d expected int=1 id=1", bus.Interrupt, bus.IrqId); end
        set_mask(4'b0000);
        bus.IntAck = 1'b1;
        tick();
        bus.IntAck = 1'b0;
        tests++; if (bus.Pending !== 4'b0000) begin fails++; $display("FAIL wd_ack_wins: got %b expected 0000", bus.Pending); end
        tests++; if (bus.Interrupt !== 1'b0) begin fails++; $display("FAIL wd_ack_int: got %b expected 0", bus.Interrupt); end
        bus.IrqIn = '0;
        $display("[TB] test_withdraw done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_mask(4'b1111);
        bus.IrqIn = 4'b0001;
        tick(); tick(); tick();
        tests++; if (bus.Interrupt !== 1'b1 || bus.IrqId !== 2'd0) begin fails++; $display("FAIL b2b_assert: got int=%b id=%0d expected int=1 id=0", bus.Interrupt, bus.IrqId); end
        bus.IrqIn = 4'b0000;
        tick(); tick();
        bus.IrqIn = 4'b0001;
        tick();
        bus.IntAck = 1'b1;
        tick();
        bus.IntAck = 1'b0;
        tests++; if (bus.Pending !== 4'b0001) begin fails++; $display("FAIL b2b_set_wins: got %b expected 0001", bus.Pending); end
        tests++; if (bus.Interrupt !== 1'b0) begin fails++; $display("FAIL b2b_ack_int: got %b expected 0", bus.Interrupt); end
        tick(); tick();
        tests++; if (bus.Interrupt !== 1'b0) begin fails++; $display("FAIL b2b_hold: got %b expected 0", bus.Interrupt); end
        tick();
        tests++; if (bus.Interrupt !== 1'b1 || bus.IrqId !== 2'd0) begin fails++; $display("FAIL b2b_rerequest: got int=%b id=%0d expected int=1 id=0", bus.Interrupt, bus.IrqId); end
        bus.IrqIn = '0;
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_reset_abort();
        do_reset();
        set_mask(4'b1111);
        bus.IrqIn = 4'b0100;
        tick(); tick(); tick();
        tests++; if (bus.Interrupt !== 1'b1 || bus.IrqId !== 2'd2) begin fails++; $display("FAIL ra_assert: got int=%b id=%0d expected int=1 id=2", bus.Interrupt, bus.IrqId); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tests++; if (bus.Interrupt !== 1'b0 || bus.IrqId !== 2'd0) begin fails++; $display("FAIL ra_outputs: got int=%b id=%0d expected int=0 id=0", bus.Interrupt, bus.IrqId); end
        tests++; if (bus.Pending !== 4'b0000 || bus.Mask !== 4'b0000) begin fails++; $display("FAIL ra_regs: got pend=%b mask=%b expected 0000/0000", bus.Pending, bus.Mask); end
        // Cleared synchronisers see the held level as one fresh rise; service it once.
        set_mask(4'b1111);
        tick(); tick();
        bus.IntAck = bus.Interrupt;
        tick();
        bus.IntAck = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        tests++; if (bus.Pending !== 4'b0000 || bus.Interrupt !== 1'b0) begin fails++; $display("FAIL ra_held_level: got pend=%b int=%b expected 0000/0", bus.Pending, bus.Interrupt); end
        bus.IrqIn = 4'b0000;
        tick(); tick();
        bus.IrqIn = 4'b0100;
        tick(); tick(); tick();
        tests++; if (bus.Interrupt !== 1'b1 || bus.IrqId !== 2'd2 || bus.Pending !== 4'b0100) begin fails++; $display("FAIL ra_toggle: got int=%b id=%0d pend=%b expected 1/2/0100", bus.Interrupt, bus.IrqId, bus.Pending); end
        bus.IrqIn = '0;
        $display("[TB] test_reset_abort done");
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset      = 1'b0;
        bus.IrqIn  = '0;
        bus.MaskWE = 1'b0;
        bus.MaskWD = '0;
        bus.IntAck = 1'b0;
        tick();
        test_reset();
        test_latency();
        test_round_robin();
        test_masked_pending();
        test_withdraw();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
